// File: rtl/cbb_rs_pipe.sv
// Valid/ready register-slice pipeline: P_STAGES chained slices in bypass,
// forward, backward (skid) or full cut mode, with registered occupancy status.
module cbb_rs_pipe #(
  parameter int P_DATA_WIDTH = 64,
  parameter int P_MODE       = 3,
  parameter int P_STAGES     = 1
) (
  input  logic                                 i_clk,
  input  logic                                 i_rstn,
  input  logic                                 slv_i_valid,
  input  logic [P_DATA_WIDTH-1:0]              slv_i_data,
  output logic                                 slv_o_ready,
  output logic                                 mst_o_valid,
  output logic [P_DATA_WIDTH-1:0]              mst_o_data,
  input  logic                                 mst_i_ready,
  output logic [$clog2(2*P_STAGES+1)-1:0]      o_occupancy,
  output logic                                 o_busy
);

  localparam int OCC_W = $clog2(2*P_STAGES+1);
  localparam int S     = P_STAGES;

  generate
    if (P_DATA_WIDTH < 1) begin : g_bad_width
      $error("cbb_rs_pipe: P_DATA_WIDTH must be >= 1");
    end
    if (P_MODE < 0 || P_MODE > 3) begin : g_bad_mode
      $error("cbb_rs_pipe: P_MODE must be 0..3");
    end
    if (P_MODE != 0 && (P_STAGES < 1 || P_STAGES > 8)) begin : g_bad_stages
      $error("cbb_rs_pipe: P_STAGES must be 1..8");
    end
  endgenerate

  logic [OCC_W-1:0] occ_d;
  logic [OCC_W-1:0] occ_q;

  // Occupancy is taken from next-state flags so it matches flag state after the edge
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) occ_q <= '0;
    else         occ_q <= occ_d;
  end

  assign o_occupancy = occ_q;
  assign o_busy      = |occ_q;

  generate
    if (P_MODE == 0) begin : g_bypass
      assign slv_o_ready = mst_i_ready;
      assign mst_o_valid = slv_i_valid;
      assign mst_o_data  = slv_i_data;
      assign occ_d       = '0;

    end else if (P_MODE == 1) begin : g_fwd
      logic [S-1:0]            v_q, v_d;
      logic [P_DATA_WIDTH-1:0] data_q [S];
      logic [P_DATA_WIDTH-1:0] data_d [S];
      logic [S:0]              vld;
      logic [S:0]              rdy;
      logic [P_DATA_WIDTH-1:0] dat [S+1];

      // Ready ripples backwards: a stage accepts when empty or draining
      always_comb begin
        vld    = {v_q, slv_i_valid};
        dat[0] = slv_i_data;
        for (int k = 0; k < S; k++) dat[k+1] = data_q[k];
        rdy    = '0;
        rdy[S] = mst_i_ready;
        for (int k = S-1; k >= 0; k--) rdy[k] = ~v_q[k] | rdy[k+1];
        v_d    = v_q;
        data_d = data_q;
        for (int k = 0; k < S; k++) begin
          if (vld[k] & rdy[k]) begin
            v_d[k]    = 1'b1;
            data_d[k] = dat[k];
          end else if (v_q[k] & rdy[k+1]) begin
            v_d[k] = 1'b0;
          end
        end
        occ_d = OCC_W'($countones(v_d));
      end

      always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) v_q <= '0;
        else         v_q <= v_d;
      end

      always_ff @(posedge i_clk) data_q <= data_d;

      assign slv_o_ready = rdy[0];
      assign mst_o_valid = vld[S];
      assign mst_o_data  = dat[S];

    end else if (P_MODE == 2) begin : g_bwd
      logic [S-1:0]            s_q, s_d;
      logic [P_DATA_WIDTH-1:0] skid_q [S];
      logic [P_DATA_WIDTH-1:0] skid_d [S];
      logic [S:0]              vld;
      logic [S:0]              rdy;
      logic [P_DATA_WIDTH-1:0] dat [S+1];

      // An empty skid passes the beat through; it only captures when downstream stalls
      always_comb begin
        vld[0] = slv_i_valid;
        dat[0] = slv_i_data;
        for (int k = 0; k < S; k++) begin
          vld[k+1] = s_q[k] | vld[k];
          dat[k+1] = s_q[k] ? skid_q[k] : dat[k];
        end
        rdy    = {mst_i_ready, ~s_q};
        s_d    = s_q;
        skid_d = skid_q;
        for (int k = 0; k < S; k++) begin
          if (s_q[k]) begin
            if (rdy[k+1]) s_d[k] = 1'b0;
          end else if (vld[k] & ~rdy[k+1]) begin
            s_d[k]    = 1'b1;
            skid_d[k] = dat[k];
          end
        end
        occ_d = OCC_W'($countones(s_d));
      end

      always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) s_q <= '0;
        else         s_q <= s_d;
      end

      always_ff @(posedge i_clk) skid_q <= skid_d;

      assign slv_o_ready = rdy[0];
      assign mst_o_valid = vld[S];
      assign mst_o_data  = dat[S];

    end else begin : g_full
      logic [S-1:0]            m_q, m_d;
      logic [S-1:0]            s_q, s_d;
      logic [P_DATA_WIDTH-1:0] main_q [S];
      logic [P_DATA_WIDTH-1:0] main_d [S];
      logic [P_DATA_WIDTH-1:0] skid_q [S];
      logic [P_DATA_WIDTH-1:0] skid_d [S];
      logic [S:0]              vld;
      logic [S:0]              rdy;
      logic [P_DATA_WIDTH-1:0] dat [S+1];
      logic                    in_xfer;
      logic                    out_xfer;

      // Skid only fills while main is stuck, so it never holds data with in_xfer set
      always_comb begin
        vld    = {m_q, slv_i_valid};
        rdy    = {mst_i_ready, ~s_q};
        dat[0] = slv_i_data;
        for (int k = 0; k < S; k++) dat[k+1] = main_q[k];
        m_d      = m_q;
        s_d      = s_q;
        main_d   = main_q;
        skid_d   = skid_q;
        in_xfer  = 1'b0;
        out_xfer = 1'b0;
        for (int k = 0; k < S; k++) begin
          in_xfer  = vld[k] & rdy[k];
          out_xfer = m_q[k] & rdy[k+1];
          if (out_xfer) begin
            if (s_q[k]) begin
              main_d[k] = skid_q[k];
              s_d[k]    = 1'b0;
            end else begin
              m_d[k] = 1'b0;
            end
          end
          if (in_xfer) begin
            if (~m_q[k] | out_xfer) begin
              main_d[k] = dat[k];
              m_d[k]    = 1'b1;
            end else begin
              skid_d[k] = dat[k];
              s_d[k]    = 1'b1;
            end
          end
        end
        occ_d = OCC_W'($countones(m_d)) + OCC_W'($countones(s_d));
      end

      always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
          m_q <= '0;
          s_q <= '0;
        end else begin
          m_q <= m_d;
          s_q <= s_d;
        end
      end

      always_ff @(posedge i_clk) begin
        main_q <= main_d;
        skid_q <= skid_d;
      end

      assign slv_o_ready = rdy[0];
      assign mst_o_valid = vld[S];
      assign mst_o_data  = dat[S];
    end
  endgenerate

endmodule
